gx_reset_ctrl: RTL and testbench

GX_RESET_CTRL -- requirements
Module: gx_reset_ctrl

---
 rtl/gx_reset_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_gx_reset_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/gx_reset_ctrl.sv
// gx_reset_ctrl: transceiver reset sequencer (TX_ANA > TX_DIG > RX_ANA > RX_LOCK > RX_DIG > READY).
// Define GX_RST_LOCK_TIMEOUT_EN to restart the RX analog stage when lock takes too long.
module gx_reset_ctrl #(
  parameter int T_ANALOG  = 100,
  parameter int T_DIGITAL = 50,
  parameter int T_LTD     = 200,
  parameter int T_TIMEOUT = 65535
) (
  input  logic clk,
  input  logic nreset,
  input  logic tx_cal_busy_i,
  input  logic rx_cal_busy_i,
  input  logic rx_is_lockedtodata_i,
  output logic tx_analogreset_o,
  output logic tx_digitalreset_o,
  output logic rx_analogreset_o,
  output logic rx_digitalreset_o,
  output logic tx_ready_o,
  output logic rx_ready_o
);

  localparam int T_MAX_A = (T_ANALOG > T_DIGITAL) ? T_ANALOG : T_DIGITAL;
  localparam int T_MAX_B = (T_LTD > T_TIMEOUT) ? T_LTD : T_TIMEOUT;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX) + 1;

  localparam logic [2:0] ST_TX_ANA  = 3'd0;
  localparam logic [2:0] ST_TX_DIG  = 3'd1;
  localparam logic [2:0] ST_RX_ANA  = 3'd2;
  localparam logic [2:0] ST_RX_LOCK = 3'd3;
  localparam logic [2:0] ST_RX_DIG  = 3'd4;
  localparam logic [2:0] ST_READY   = 3'd5;

  logic          r_tx_busy_s1, r_tx_busy_s2;
  logic          r_rx_busy_s1, r_rx_busy_s2;
  logic          r_lock_s1, r_lock_s2;
  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_cnt_last;
  logic          r_tx_ana, r_tx_dig, r_rx_ana, r_rx_dig, r_tx_rdy, r_rx_rdy;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_tx_busy_s1 <= 1'b1;
      r_tx_busy_s2 <= 1'b1;
      r_rx_busy_s1 <= 1'b1;
      r_rx_busy_s2 <= 1'b1;
      r_lock_s1    <= 1'b0;
      r_lock_s2    <= 1'b0;
    end else begin
      r_tx_busy_s1 <= tx_cal_busy_i;
      r_tx_busy_s2 <= r_tx_busy_s1;
      r_rx_busy_s1 <= rx_cal_busy_i;
      r_rx_busy_s2 <= r_rx_busy_s1;
      r_lock_s1    <= rx_is_lockedtodata_i;
      r_lock_s2    <= r_lock_s1;
    end
  end

  // The transition fires on the edge that would take the counter to zero,
  // so each stage spends exactly its parameter in counted cycles.
  assign w_cnt_last = (r_cnt <= CW'(1));

`ifdef GX_RST_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(T_TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_to_hit;

  assign w_to_hit = (r_state == ST_RX_LOCK) && (r_to_cnt >= TW'(T_TIMEOUT - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_RX_LOCK) && (w_state_nxt == ST_RX_LOCK)) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_TX_ANA: begin
        if (!r_tx_busy_s2) begin
          if (w_cnt_last) begin
            w_state_nxt = ST_TX_DIG;
            w_cnt_nxt   = CW'(T_DIGITAL);
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      ST_TX_DIG: begin
        if (w_cnt_last) begin
          w_state_nxt = ST_RX_ANA;
          w_cnt_nxt   = CW'(T_ANALOG);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_RX_ANA: begin
        if (!r_rx_busy_s2) begin
          if (w_cnt_last) begin
            w_state_nxt = ST_RX_LOCK;
            w_cnt_nxt   = CW'(T_LTD);
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      ST_RX_LOCK: begin
        if (!r_lock_s2) begin
          w_cnt_nxt = CW'(T_LTD);
        end else if (w_cnt_last) begin
          w_state_nxt = ST_RX_DIG;
          w_cnt_nxt   = CW'(T_DIGITAL);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_RX_DIG: begin
        if (!r_lock_s2) begin
          w_state_nxt = ST_RX_LOCK;
          w_cnt_nxt   = CW'(T_LTD);
        end else if (w_cnt_last) begin
          w_state_nxt = ST_READY;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_READY: begin
        // Calibration restarts the analog stage, so it wins over a plain lock loss.
        if (r_rx_busy_s2) begin
          w_state_nxt = ST_RX_ANA;
          w_cnt_nxt   = CW'(T_ANALOG);
        end else if (!r_lock_s2) begin
          w_state_nxt = ST_RX_LOCK;
          w_cnt_nxt   = CW'(T_LTD);
        end
      end
      default: begin
        w_state_nxt = ST_TX_ANA;
        w_cnt_nxt   = CW'(T_ANALOG);
      end
    endcase
`ifdef GX_RST_LOCK_TIMEOUT_EN
    if (w_to_hit && (w_state_nxt == ST_RX_LOCK)) begin
      w_state_nxt = ST_RX_ANA;
      w_cnt_nxt   = CW'(T_ANALOG);
    end
`endif
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state  <= ST_TX_ANA;
      r_cnt    <= CW'(T_ANALOG);
      r_tx_ana <= 1'b1;
      r_tx_dig <= 1'b1;
      r_rx_ana <= 1'b1;
      r_rx_dig <= 1'b1;
      r_tx_rdy <= 1'b0;
      r_rx_rdy <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tx_ana <= (w_state_nxt == ST_TX_ANA);
      r_tx_dig <= (w_state_nxt == ST_TX_ANA) || (w_state_nxt == ST_TX_DIG);
      r_rx_ana <= (w_state_nxt == ST_TX_ANA) || (w_state_nxt == ST_TX_DIG) ||
                  (w_state_nxt == ST_RX_ANA);
      r_rx_dig <= (w_state_nxt != ST_READY);
      r_tx_rdy <= (w_state_nxt != ST_TX_ANA) && (w_state_nxt != ST_TX_DIG);
      r_rx_rdy <= (w_state_nxt == ST_READY);
    end
  end

  assign tx_analogreset_o  = r_tx_ana;
  assign tx_digitalreset_o = r_tx_dig;
  assign rx_analogreset_o  = r_rx_ana;
  assign rx_digitalreset_o = r_rx_dig;
  assign tx_ready_o        = r_tx_rdy;
  assign rx_ready_o        = r_rx_rdy;

endmodule

// File: tb/tb_gx_reset_ctrl.sv
// tb_gx_reset_ctrl: directed checks of the reset sequencer with short hold times.
// Output vector order: {tx_ana, tx_dig, rx_ana, rx_dig, tx_ready, rx_ready}.
module tb_gx_reset_ctrl;

  localparam logic [5:0] V_TX_ANA = 6'b111100;
  localparam logic [5:0] V_TX_DIG = 6'b011100;
  localparam logic [5:0] V_RX_ANA = 6'b001110;
  localparam logic [5:0] V_RX_LCK = 6'b000110;
  localparam logic [5:0] V_READY  = 6'b000011;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  logic tx_busy = 1'b0;
  logic rx_busy = 1'b0;
  logic lock = 1'b1;
  logic tx_ana, tx_dig, rx_ana, rx_dig, tx_rdy, rx_rdy;
  logic [5:0] outs;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign outs = {tx_ana, tx_dig, rx_ana, rx_dig, tx_rdy, rx_rdy};

  gx_reset_ctrl #(
    .T_ANALOG (4),
    .T_DIGITAL(3),
    .T_LTD    (5),
    .T_TIMEOUT(20)
  ) dut (
    .clk                 (clk),
    .nreset              (nreset),
    .tx_cal_busy_i       (tx_busy),
    .rx_cal_busy_i       (rx_busy),
    .rx_is_lockedtodata_i(lock),
    .tx_analogreset_o    (tx_ana),
    .tx_digitalreset_o   (tx_dig),
    .rx_analogreset_o    (rx_ana),
    .rx_digitalreset_o   (rx_dig),
    .tx_ready_o          (tx_rdy),
    .rx_ready_o          (rx_rdy)
  );

  task automatic chk_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  // Edge numbers count from the first rising edge after release.
  task automatic run_seq(input string tag);
    step(5); chk_eq({tag, "_tx_ana_hold"}, outs, V_TX_ANA);
    step(1); chk_eq({tag, "_tx_ana_fall"}, outs, V_TX_DIG);
    step(2); chk_eq({tag, "_tx_dig_hold"}, outs, V_TX_DIG);
    step(1); chk_eq({tag, "_tx_ready"}, outs, V_RX_ANA);
    step(3); chk_eq({tag, "_rx_ana_hold"}, outs, V_RX_ANA);
    step(1); chk_eq({tag, "_rx_ana_fall"}, outs, V_RX_LCK);
    step(7); chk_eq({tag, "_rx_dig_hold"}, outs, V_RX_LCK);
    step(1); chk_eq({tag, "_rx_ready"}, outs, V_READY);
  endtask

  initial begin
    #2 nreset = 1'b0;
    #1 chk_eq("reset_async", outs, V_TX_ANA);
    step(2); chk_eq("reset_hold", outs, V_TX_ANA);
    release_rst();
    run_seq("s1");

    // one-cycle lock drop in READY
    lock = 1'b0; step(1);
    lock = 1'b1; step(1); chk_eq("drop_not_yet", outs, V_READY);
    step(1); chk_eq("drop_seen", outs, V_RX_LCK);
    step(7); chk_eq("relock_hold", outs, V_RX_LCK);
    step(1); chk_eq("relock_ready", outs, V_READY);

    // lock glitch inside RX_LOCK reloads the lock counter
    lock = 1'b0; step(2); chk_eq("glitch_ready", outs, V_READY);
    step(1); chk_eq("glitch_lock", outs, V_RX_LCK);
    lock = 1'b1; step(3);
    lock = 1'b0; step(1);
    lock = 1'b1; step(9); chk_eq("reload_hold", outs, V_RX_LCK);
    step(1); chk_eq("reload_ready", outs, V_READY);

    // cal_busy and lock loss together: analog restart wins
    rx_busy = 1'b1; lock = 1'b0;
    step(2); chk_eq("prio_not_yet", outs, V_READY);
    step(1); chk_eq("prio_rx_ana", outs, V_RX_ANA);
    rx_busy = 1'b0; lock = 1'b1;
    step(5); chk_eq("prio_ana_hold", outs, V_RX_ANA);
    step(1); chk_eq("prio_ana_fall", outs, V_RX_LCK);
    step(7); chk_eq("prio_dig_hold", outs, V_RX_LCK);
    step(1); chk_eq("prio_ready", outs, V_READY);

    // reset pulse during RX_DIG
    lock = 1'b0; step(1);
    lock = 1'b1; step(8); chk_eq("in_rx_dig", outs, V_RX_LCK);
    nreset = 1'b0;
    #1 chk_eq("mid_reset_async", outs, V_TX_ANA);
    step(1);
    release_rst();
    run_seq("s2");

    // TX calibration held for 10 cycles after release
    tx_busy = 1'b1; nreset = 1'b0;
    #1 chk_eq("busy_reset", outs, V_TX_ANA);
    step(1);
    release_rst();
    step(10); tx_busy = 1'b0;
    step(5); chk_eq("busy_tx_ana_hold", outs, V_TX_ANA);
    step(1); chk_eq("busy_tx_ana_fall", outs, V_TX_DIG);

    // lock never arrives
    lock = 1'b0; nreset = 1'b0;
    #1 chk_eq("nolock_reset", outs, V_TX_ANA);
    step(1);
    release_rst();
    step(13); chk_eq("nolock_entry", outs, V_RX_LCK);
`ifdef GX_RST_LOCK_TIMEOUT_EN
    step(19); chk_eq("timeout_hold", outs, V_RX_LCK);
    step(1); chk_eq("timeout_fire", outs, V_RX_ANA);
`else
    step(40); chk_eq("no_timeout", outs, V_RX_LCK);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
